// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; the default is registered read (latency 1).
module sync_fifo_prog #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [AW:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [AW:0] AFULL_C  = PW'(AFULL_THRESH);
    localparam logic [AW:0] AEMPTY_C = PW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        wr_acc, rd_acc;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // flush suppresses both requests, so it also prevents error flags from being set
    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr_acc && !rd_acc)      count_d = count_q + PW'(1);
            else if (rd_acc && !wr_acc) count_d = count_q - PW'(1);
        end
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full && !flush)  overflow_d  = 1'b1;
        if (rd_en && empty && !flush) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign dout       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign dout_valid = ~empty;
`else
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = rd_acc;
        if (rd_acc) dout_d = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
`endif

endmodule
